icache_line_fetcher: RTL

- Responder side of the icache refill interface. Accepts a level line-fill request (req_i, req_addr_i) and issues one AXI4 INCR burst read of a 64-byte line.
- Buffers the 8 returned beats into a 512-bit line buffer, then exposes it to the cache 64 bits at a time, selected by fifo_idx_i.
- Sits between the icache and the AXI interconnect. Single outstanding transaction.

---
 rtl/icache_line_fetcher.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/icache_line_fetcher.sv
// icache_line_fetcher: on a line-fill request from the icache, fetches one
// 64-byte line as a single 8-beat AXI4 INCR read burst. The beats land in a
// 512-bit line buffer, and the cache then reads that buffer back one 64-bit
// word at a time. Only one transaction is in flight at any time.
module icache_line_fetcher #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [63:0] req_addr_i,
    input  logic [8:0]  fifo_idx_i,
    input  logic        fifo_done_i,
    output logic [63:0] data_o,
    output logic        done_o,
    output logic        err_o,
    output logic [3:0]  arid,
    output logic [63:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [63:0]  araddr_q, araddr_d;
    logic         arvalid_q, arvalid_d;
    logic         rready_q, rready_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic [2:0]   beat_q, beat_d;
    logic [511:0] line_buf_q, line_buf_d;

    // These inputs do not affect behaviour. The low address and index bits
    // only select bytes within a line or within a word, and the interconnect
    // returns exactly one ID.
    logic unused_inputs;
    assign unused_inputs = ^{rid, fifo_done_i, fifo_idx_i[5:0], req_addr_i[5:0]};

    // Next-state logic. It sequences request -> address phase -> data beats
    // -> buffer held for the cache.
    always_comb begin
        state_d    = state_q;
        araddr_d   = araddr_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        done_d     = done_q;
        err_d      = err_q;
        beat_d     = beat_q;
        line_buf_d = line_buf_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    araddr_d  = {req_addr_i[63:6], 6'b0};
                    err_d     = 1'b0;
                    beat_d    = 3'd0;
                    arvalid_d = 1'b1;
                    state_d   = ST_AR;
                end
            end
            ST_AR: begin
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_R;
                end
            end
            ST_R: begin
                if (rvalid && rready_q) begin
                    line_buf_d[{beat_q, 6'b0} +: 64] = rdata;
                    beat_d = beat_q + 3'd1;
                    if (rresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                    if (rlast || (beat_q == 3'd7)) begin
                        rready_d = 1'b0;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                        if (!(rlast && (beat_q == 3'd7))) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (!req_i) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and handshake registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            araddr_q  <= 64'd0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            beat_q    <= 3'd0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            done_q    <= done_d;
            err_q     <= err_d;
            beat_q    <= beat_d;
        end
    end

    // The line buffer has no reset. Its contents mean nothing until done_o rises.
    always_ff @(posedge clk) begin
        line_buf_q <= line_buf_d;
    end

    assign data_o  = line_buf_q[{fifo_idx_i[8:6], 6'b0} +: 64];
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign arid    = AXI_ID;
    assign araddr  = araddr_q;
    assign arlen   = 8'd7;
    assign arsize  = 3'b011;
    assign arburst = 2'b01;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

endmodule
